seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the 4-digit scanned seven-segment driver in the disp_num design. Samples the multiplexed AN/SEGMENT bus, waits for each digit slot to settle, and decodes the segment pattern back to a hex nibble and decimal-point bit. Once all four digits have been captured, it presents the reassembled 16-bit value with a one-cycle valid pulse. Used as an on-board loopback monitor and as a self-checking receiver in display benches.

## Interface
- STABLE_CYC, 4: consecutive identical samples required before a digit is accepted (range 2..255).
- clk  input  1  system clock; all logic rises on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- AN  input  4  digit enables, active-low; AN[i]=0 selects digit i; digit 0 is the least-significant nibble.
- SEGMENT  input  8  segments, active-low, {dp,g,f,e,d,c,b,a}.
- num  output  16  last complete frame; num[4i+3:4i] is digit i.
- dp  output  4  decimal-point state per digit of the last frame (1 = lit).
- frame_valid  output  1  one-cycle pulse when num, dp and seg_err update.
- seg_err  output  1  last frame contained at least one undecodable pattern.

## Operation
- Sample register: holds {AN,SEGMENT} from the previous cycle. A sample is "valid-select" when AN has exactly one bit low.
- FSM states:
  - HUNT: waits for a valid-select sample. On one, loads stab_cnt=1 and goes to SETTLE.
  - SETTLE: an identical valid-select sample increments stab_cnt. On stab_cnt==STABLE_CYC, captures the digit and goes to HOLD. Any change in AN or SEGMENT returns to HUNT (stab_cnt cleared). A non-valid-select sample also returns to HUNT.
  - HOLD: the digit has been captured once. Stays in HOLD while the sample is unchanged, so a static bus is captured only once. Any change returns to HUNT.
- Digit capture:
  - The decode table (active-low, SEGMENT[6:0], hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - Any other pattern, including blank 7F, decodes to nibble 0 and sets the frame error bit.
  - dp bit = ~SEGMENT[7].
  - The nibble and dp are written into a shadow frame buffer at slot i, and mask[i] is set.
  - Capturing a slot that is already set in mask overwrites that slot; the mask is unchanged.
- Frame completion:
  - Occurs on the cycle mask becomes 4'b1111.
  - The shadow buffer, including the digit just captured, is copied to num/dp. The error accumulator is copied to seg_err.
  - frame_valid pulses, mask clears and the accumulator clears.
  - The next frame starts fresh.
- Arithmetic: stab_cnt is 8 bits and saturates at STABLE_CYC. No wrap is possible.

## Timing
- Reset (async assert, sync deassert handled at top):
  - num=0, dp=0, frame_valid=0, seg_err=0.
  - mask=0, FSM=HUNT, stab_cnt=0, sample register=all ones.
- Capture latency: a digit held constant from cycle t is captured at cycle t+STABLE_CYC. Add 2 cycles when the synchronizer is enabled.
- Output latency: frame_valid rises on the same clock edge as the fourth capture, with num valid that same cycle.
- Outputs hold between pulses. frame_valid is never asserted for two consecutive cycles.
- Reset mid-frame discards the partial frame. No pulse is produced.
- A glitch shorter than STABLE_CYC cycles is never captured.

## Configuration
- SEG_SYNC_EN defined:
  - AN and SEGMENT pass through a two-flop synchronizer before the sample register.
  - The synchronizer resets to all ones.
  - All latencies grow by 2 cycles.
- SEG_SYNC_EN undefined: inputs feed the sample register directly, for same-clock loopback only.

## Structure
- Shared package seg_pkg:
  - decode table constants SEG_0..SEG_F;
  - FSM state typedef (HUNT, SETTLE, HOLD);
  - SEG_BLANK=7'h7F.
- One sub-module, seg7_to_hex: combinational; input 7-bit pattern; outputs nibble and valid flag.
- FSM, counters, mask and frame registers live in seg_scan_decoder.

## Test plan
- Static scan, STABLE_CYC=4:
  - Stimulus: drive AN=E/SEG=F9, then D/A4, B/B0, 7/99, 6 cycles each.
  - Response: one frame_valid with num=16'h4321, dp=0, seg_err=0.
- Glitch rejection:
  - Stimulus: insert a 3-cycle AN=E/SEG=80 between valid digits.
  - Response: slot 0 is not updated by the glitch.
- Bad pattern:
  - Stimulus: digit 2 driven with SEG=FF (blank), others valid "A", "b", "d".
  - Response: num[11:8]=0, seg_err=1. The next clean frame returns seg_err=0.
- Decimal point and overwrite:
  - Stimulus: digit 1 sent twice, first with SEG=C0 then 40, before digits 0, 2, 3 complete the frame.
  - Response: num[7:4]=0, dp=4'b0010, single pulse.
- Invalid select:
  - Stimulus: AN=C or F for 20 cycles.
  - Response: no capture, FSM stays in HUNT.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 after two digits are captured.
  - Response: all outputs are 0. A complete frame is then needed for the next pulse.
- Repeat the static-scan scenario with SEG_SYNC_EN defined.
  - Response: frame_valid is 2 cycles later than without the macro.

Source files
------------

// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the scanned seven-segment receiver.
//   - SEG_0..SEG_F : active-low segment patterns {g,f,e,d,c,b,a} per hex digit
//   - SEG_BLANK    : all segments off
//   - state_t      : digit-capture FSM states
//   - single_low() : true when exactly one digit enable is asserted (low)
//   - slot_of()    : index of the asserted (low) digit enable
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        HUNT,
        SETTLE,
        HOLD
    } state_t;

    function automatic logic single_low(input logic [3:0] an);
        return ($countones(~an) == 1);
    endfunction

    function automatic logic [1:0] slot_of(input logic [3:0] an);
        logic [1:0] s;
        s = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!an[i]) s = 2'(i);
        end
        return s;
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// ----------------------------------------------------------------------------
// seg7_to_hex
// Combinational decode of an active-low seven-segment pattern to a hex nibble.
//   pat [6:0] : segment pattern {g,f,e,d,c,b,a}, active-low
//   nib [3:0] : decoded hex value (0 when the pattern is not a hex glyph)
//   ok        : 1 when pat is one of the sixteen hex glyphs
// ----------------------------------------------------------------------------
module seg7_to_hex
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] nib,
    output logic       ok
);

    always_comb begin
        nib = '0;
        ok  = 1'b1;
        case (pat)
            SEG_0:     nib = 4'h0;
            SEG_1:     nib = 4'h1;
            SEG_2:     nib = 4'h2;
            SEG_3:     nib = 4'h3;
            SEG_4:     nib = 4'h4;
            SEG_5:     nib = 4'h5;
            SEG_6:     nib = 4'h6;
            SEG_7:     nib = 4'h7;
            SEG_8:     nib = 4'h8;
            SEG_9:     nib = 4'h9;
            SEG_A:     nib = 4'hA;
            SEG_B:     nib = 4'hB;
            SEG_C:     nib = 4'hC;
            SEG_D:     nib = 4'hD;
            SEG_E:     nib = 4'hE;
            SEG_F:     nib = 4'hF;
            SEG_BLANK: ok  = 1'b0;
            default:   ok  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// seg_scan_decoder
// Receiver for a 4-digit multiplexed seven-segment bus. Each digit slot must
// be seen unchanged for STABLE_CYC consecutive samples before it is captured;
// once all four slots have been captured the frame is published with a
// one-cycle frame_valid pulse.
//
// Parameters:
//   STABLE_CYC  : identical samples needed to accept a digit (2..255)
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   AN[3:0]     : digit enables, active-low, AN[i]=0 selects digit i
//   SEGMENT[7:0]: segments, active-low, {dp,g,f,e,d,c,b,a}
//   num[15:0]   : last complete frame, num[4i+3:4i] is digit i
//   dp[3:0]     : decimal point per digit of last frame (1 = lit)
//   frame_valid : one-cycle pulse when num/dp/seg_err update
//   seg_err     : last frame held at least one undecodable pattern
// Build option:
//   SEG_SYNC_EN : insert a two-flop synchronizer on AN/SEGMENT (+2 cycles)
// ----------------------------------------------------------------------------
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  AN,
    input  logic [7:0]  SEGMENT,
    output logic [15:0] num,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        seg_err
);

    localparam logic [7:0] STAB = 8'(STABLE_CYC);

    logic [11:0] bus_in;

`ifdef SEG_SYNC_EN
    logic [11:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {AN, SEGMENT};
            sync2 <= sync1;
        end
    end

    assign bus_in = sync2;
`else
    assign bus_in = {AN, SEGMENT};
`endif

    // Previous sample, used to detect any change on the bus.
    logic [11:0] samp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) samp <= '1;
        else        samp <= bus_in;
    end

    logic sel_ok, same;
    assign sel_ok = single_low(bus_in[11:8]);
    assign same   = (bus_in == samp);

    // ---------------- FSM ----------------
    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A change drops back to hunting, and the new sample is judged in the
    // same cycle so it already counts as the first of its run; this keeps the
    // capture latency at STABLE_CYC from the change regardless of what came
    // before it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HUNT: begin
                if (sel_ok) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end
            end
            SETTLE, HOLD: begin
                if (!same) begin
                    state_d = sel_ok ? SETTLE : HUNT;
                    cnt_d   = sel_ok ? 8'd1 : 8'd0;
                end else if (state_q == SETTLE) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == STAB) state_d = HOLD;
                end
            end
            default: begin
                state_d = HUNT;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        capture = (state_q == SETTLE) && same && ((cnt_q + 8'd1) == STAB);
    end

    // ---------------- digit decode ----------------
    logic [3:0] nib;
    logic       nib_ok;

    seg7_to_hex u_dec (
        .pat (bus_in[6:0]),
        .nib (nib),
        .ok  (nib_ok)
    );

    // ---------------- frame assembly ----------------
    logic [15:0] shadow_num, shadow_num_nxt;
    logic [3:0]  shadow_dp, shadow_dp_nxt;
    logic [3:0]  mask, mask_nxt;
    logic        err_acc, err_nxt;
    logic [1:0]  slot;

    assign slot = slot_of(bus_in[11:8]);

    always_comb begin
        shadow_num_nxt                    = shadow_num;
        shadow_num_nxt[{slot, 2'b00} +: 4] = nib;
        shadow_dp_nxt                     = shadow_dp;
        shadow_dp_nxt[slot]               = ~bus_in[7];
        mask_nxt                          = mask | ~bus_in[11:8];
        err_nxt                           = err_acc | ~nib_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_num  <= '0;
            shadow_dp   <= '0;
            mask        <= '0;
            err_acc     <= 1'b0;
            num         <= '0;
            dp          <= '0;
            seg_err     <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (capture) begin
                if (mask_nxt == 4'b1111) begin
                    num         <= shadow_num_nxt;
                    dp          <= shadow_dp_nxt;
                    seg_err     <= err_nxt;
                    frame_valid <= 1'b1;
                    shadow_num  <= '0;
                    shadow_dp   <= '0;
                    mask        <= '0;
                    err_acc     <= 1'b0;
                end else begin
                    shadow_num  <= shadow_num_nxt;
                    shadow_dp   <= shadow_dp_nxt;
                    mask        <= mask_nxt;
                    err_acc     <= err_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_decoder
// Self-checking bench for seg_scan_decoder: directed scenarios plus random
// bus traffic, compared every cycle against a run-length reference model.
// ----------------------------------------------------------------------------
module tb_seg_scan_decoder;

    localparam int STABLE = 4;
`ifdef SEG_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  AN = 4'hF;
    logic [7:0]  SEGMENT = 8'hFF;
    logic [15:0] num;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        seg_err;

    seg_scan_decoder #(.STABLE_CYC(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .AN          (AN),
        .SEGMENT     (SEGMENT),
        .num         (num),
        .dp          (dp),
        .frame_valid (frame_valid),
        .seg_err     (seg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses = 0;
    int last_pulse_cyc = -1;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- reference model ----------------
    // A digit is captured when a run of identical single-select bus values
    // reaches STABLE samples; four distinct slots make a frame.
    logic [11:0] m_prev, m_d1, m_d2;
    int          m_run;
    logic [15:0] m_shadow;
    logic [3:0]  m_sdp, m_mask;
    logic        m_err;
    logic [15:0] e_num;
    logic [3:0]  e_dp;
    logic        e_err, e_fv;

    task automatic model_reset();
        m_prev = 12'hFFF; m_d1 = 12'hFFF; m_d2 = 12'hFFF; m_run = 0;
        m_shadow = '0; m_sdp = '0; m_mask = '0; m_err = 1'b0;
        e_num = '0; e_dp = '0; e_err = 1'b0; e_fv = 1'b0;
    endtask

    task automatic model_step();
        logic [11:0] cur;
        int idx, cnt0;
        logic [3:0] nv;
        logic found;
        cur = (LAT == 2) ? m_d2 : {AN, SEGMENT};
        m_d2 = m_d1;
        m_d1 = {AN, SEGMENT};
        e_fv = 1'b0;
        if (cur == m_prev) m_run = m_run + 1; else m_run = 1;
        m_prev = cur;
        cnt0 = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!cur[8+i]) begin cnt0++; idx = i; end
        if (cnt0 == 1 && m_run == STABLE) begin
            found = 1'b0; nv = 4'h0;
            for (int k = 0; k < 16; k++) if (tbl[k] == cur[6:0]) begin found = 1'b1; nv = 4'(k); end
            if (!found) m_err = 1'b1;
            m_shadow[idx*4 +: 4] = nv;
            m_sdp[idx] = ~cur[7];
            m_mask[idx] = 1'b1;
            if (m_mask == 4'hF) begin
                e_num = m_shadow; e_dp = m_sdp; e_err = m_err; e_fv = 1'b1;
                m_mask = '0; m_err = 1'b0; m_shadow = '0; m_sdp = '0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (frame_valid) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
        if (rst_n) begin
            checks++;
            if (frame_valid !== e_fv || num !== e_num || dp !== e_dp || seg_err !== e_err) begin
                failures++;
                $display("FAIL cycle_cmp cyc=%0d got fv=%b num=%h dp=%b err=%b expected fv=%b num=%h dp=%b err=%b",
                         cyc, frame_valid, num, dp, seg_err, e_fv, e_num, e_dp, e_err);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic put(input logic [3:0] a, input logic [7:0] s, input int n);
        AN = a;
        SEGMENT = s;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic frame_4321();
        put(4'hE, 8'hF9, 6);
        put(4'hD, 8'hA4, 6);
        put(4'hB, 8'hB0, 6);
        put(4'h7, 8'h99, 6);
        put(4'hF, 8'hFF, 6);
    endtask

    int p0, c0;

    initial begin
        @(posedge clk); #2;
        repeat (2) begin @(posedge clk); #2; end
        chk("reset_num", {16'h0, num}, 32'h0);
        chk("reset_flags", {28'h0, dp}, 32'h0);
        rst_n = 1'b1;
        put(4'hF, 8'hFF, 3);

        // static scan with latency pin
        p0 = pulses;
        put(4'hE, 8'hF9, 6);
        put(4'hD, 8'hA4, 6);
        put(4'hB, 8'hB0, 6);
        c0 = cyc;
        put(4'h7, 8'h99, 6);
        put(4'hF, 8'hFF, 6);
        chk("static_pulses", pulses - p0, 1);
        chk("static_latency", last_pulse_cyc, c0 + STABLE + LAT);
        chk("static_num", {16'h0, num}, 32'h4321);
        chk("static_dp_err", {27'h0, dp, seg_err}, 32'h0);

        // glitch on slot 0 shorter than STABLE
        p0 = pulses;
        put(4'hE, 8'hF9, 6);
        put(4'hD, 8'hA4, 6);
        put(4'hE, 8'h80, 3);
        put(4'hB, 8'hB0, 6);
        put(4'h7, 8'h99, 6);
        put(4'hF, 8'hFF, 6);
        chk("glitch_pulses", pulses - p0, 1);
        chk("glitch_num", {16'h0, num}, 32'h4321);

        // undecodable pattern on digit 2
        put(4'hE, 8'h88, 6);
        put(4'hD, 8'h83, 6);
        put(4'hB, 8'hFF, 6);
        put(4'h7, 8'hA1, 6);
        put(4'hF, 8'hFF, 6);
        chk("bad_num", {16'h0, num}, 32'hD0BA);
        chk("bad_err", {31'h0, seg_err}, 32'h1);
        frame_4321();
        chk("clean_err", {31'h0, seg_err}, 32'h0);

        // decimal point and slot overwrite
        p0 = pulses;
        put(4'hD, 8'hC0, 6);
        put(4'hD, 8'h40, 6);
        put(4'hE, 8'hF9, 6);
        put(4'hB, 8'hB0, 6);
        put(4'h7, 8'h99, 6);
        put(4'hF, 8'hFF, 6);
        chk("ovw_pulses", pulses - p0, 1);
        chk("ovw_num", {16'h0, num}, 32'h4301);
        chk("ovw_dp", {28'h0, dp}, 32'h2);

        // invalid selects must not fill slot 0
        p0 = pulses;
        put(4'hC, 8'hF9, 20);
        put(4'hF, 8'hF9, 20);
        put(4'hD, 8'hA4, 6);
        put(4'hB, 8'hB0, 6);
        put(4'h7, 8'h99, 6);
        put(4'hF, 8'hFF, 6);
        chk("invsel_no_pulse", pulses - p0, 0);
        put(4'hE, 8'hF9, 6);
        put(4'hF, 8'hFF, 6);
        chk("invsel_then_pulse", pulses - p0, 1);
        chk("invsel_num", {16'h0, num}, 32'h4321);

        // reset mid-frame
        put(4'hE, 8'hF9, 6);
        put(4'hD, 8'hA4, 6);
        AN = 4'hF; SEGMENT = 8'hFF;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {11'h0, num, dp, frame_valid}, 32'h0);
        chk("midrst_err", {31'h0, seg_err}, 32'h0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        p0 = pulses;
        put(4'hB, 8'hB0, 6);
        put(4'h7, 8'h99, 6);
        put(4'hF, 8'hFF, 6);
        chk("midrst_no_pulse", pulses - p0, 0);
        put(4'hE, 8'hF9, 6);
        put(4'hD, 8'hA4, 6);
        put(4'hF, 8'hFF, 6);
        chk("midrst_pulse", pulses - p0, 1);

        // random traffic, checked by the per-cycle compare
        for (int it = 0; it < 400; it++) begin
            logic [3:0] a;
            logic [7:0] s;
            int r;
            r = $urandom_range(0, 9);
            case (r % 4)
                0: a = 4'hE;
                1: a = 4'hD;
                2: a = 4'hB;
                default: a = 4'h7;
            endcase
            if (r >= 8) a = 4'($urandom);
            r = $urandom_range(0, 11);
            if (r < 10) s = {1'($urandom), tbl[$urandom_range(0, 15)]};
            else        s = 8'($urandom);
            put(a, s, $urandom_range(1, 8));
        end
        put(4'hF, 8'hFF, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
